window_mem: RTL and testbench

Parametrised window memory for the texture-analysis datapath. It stores DEPTH words of DATA_W bits in a synchronous single-port RAM. It serves two kinds of request: a LANES-wide window read/write of consecutive words starting at a base address, and a single-word read/write. Window transfers are serialised one word per cycle behind a req/rdy handshake, and read windows are returned as one flattened bus with a valid pulse.

---
 rtl/window_mem_pkg.sv | 30 +++
 rtl/window_mem_if.sv | 34 +++
 rtl/window_mem_ram.sv | 23 ++
 rtl/window_mem.sv | 167 ++++++++++++++++
 tb/tb_window_mem.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/window_mem_pkg.sv
// Shared types and constants for the window memory block.
// The CLEAR init pattern is only used when WINDOW_MEM_CLEAR_EN is defined.
package window_mem_pkg;

  typedef enum logic [2:0] {
    CLEAR = 3'd0,
    IDLE  = 3'd1,
    WRITE = 3'd2,
    READ  = 3'd3,
    FLUSH = 3'd4
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 11;
  localparam int DEF_LANES  = 50;

  localparam int         INIT_ADDR_A = 1000;
  localparam int         INIT_ADDR_B = 1101;
  localparam logic [7:0] INIT_WORD   = 8'h10;

  // A lane counter needs at least one bit even for a one-lane window.
  function automatic int cnt_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  function automatic logic is_init_addr(input int a);
    return (a == INIT_ADDR_A) || (a == INIT_ADDR_B);
  endfunction

endpackage

// File: rtl/window_mem_if.sv
// Request/response bundle of the window memory, plus the FSM state for observation.
interface window_mem_if
  import window_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LANES  = DEF_LANES
);

  // Handshake: a request is taken on the rising edge where req && rdy.
  // req/we/single/addr/wdata are sampled only on that edge; rvalid and
  // wdone are single-cycle completion pulses, and rdata holds between reads.
  logic                    req;
  logic                    rdy;
  logic                    we;
  logic                    single;
  logic [ADDR_W-1:0]       addr;
  logic [LANES*DATA_W-1:0] wdata;
  logic [LANES*DATA_W-1:0] rdata;
  logic                    rvalid;
  logic                    wdone;
  state_t                  fsm_state;

  modport master (
    output req, we, single, addr, wdata,
    input  rdy, rdata, rvalid, wdone, fsm_state
  );

  modport slave (
    input  req, we, single, addr, wdata,
    output rdy, rdata, rvalid, wdone, fsm_state
  );

endinterface

// File: rtl/window_mem_ram.sv
// Single-port synchronous RAM, one-cycle read latency, read-before-write.
// No reset: contents survive reset of the surrounding block.
module window_mem_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/window_mem.sv
// Window memory top: serialises LANES-wide window or single-word transfers into a RAM.
// Optional WINDOW_MEM_CLEAR_EN: after reset, initialise every RAM word before going idle.
module window_mem
  import window_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LANES  = DEF_LANES
) (
  input  logic         clk,
  input  logic         reset,
  window_mem_if.slave  bus
);

  localparam int CNT_W = cnt_width(LANES);
  localparam int DEPTH = 2**ADDR_W;

`ifdef WINDOW_MEM_CLEAR_EN
  localparam state_t RESET_STATE = CLEAR;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t                  state;
  state_t                  next_state;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        last_cnt;
  logic                    cnt_last;
  logic                    accept;

  logic [ADDR_W-1:0]       base_q;
  logic                    single_q;
  logic [LANES*DATA_W-1:0] wdata_q;
  logic [LANES*DATA_W-1:0] rdata_q;

  logic                    rdy_q;
  logic                    rvalid_q;
  logic                    wdone_q;
  logic                    rd_pend;
  logic [CNT_W-1:0]        rd_lane;

  logic                    ram_we;
  logic [ADDR_W-1:0]       ram_addr;
  logic [DATA_W-1:0]       ram_wdata;
  logic [DATA_W-1:0]       ram_q;

`ifdef WINDOW_MEM_CLEAR_EN
  logic [ADDR_W-1:0]       clr_addr;
`endif

  assign accept   = bus.req && rdy_q;
  assign last_cnt = single_q ? '0 : CNT_W'(LANES - 1);
  assign cnt_last = (cnt == last_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RESET_STATE;
    end else begin
      state <= next_state;
    end
  end

  // Window addresses wrap naturally through the ADDR_W-bit adder.
  always_comb begin
    next_state = state;
    ram_we     = 1'b0;
    ram_addr   = base_q + ADDR_W'(cnt);
    ram_wdata  = wdata_q[int'(cnt)*DATA_W +: DATA_W];
    case (state)
      CLEAR: begin
`ifdef WINDOW_MEM_CLEAR_EN
        ram_we    = 1'b1;
        ram_addr  = clr_addr;
        ram_wdata = is_init_addr(int'(clr_addr)) ? DATA_W'(INIT_WORD) : '0;
        if (clr_addr == ADDR_W'(DEPTH - 1)) begin
          next_state = IDLE;
        end
`else
        next_state = IDLE;
`endif
      end
      IDLE: begin
        if (accept) begin
          next_state = bus.we ? WRITE : READ;
        end
      end
      WRITE: begin
        ram_we = 1'b1;
        if (cnt_last) begin
          next_state = IDLE;
        end
      end
      READ: begin
        if (cnt_last) begin
          next_state = FLUSH;
        end
      end
      FLUSH: begin
        next_state = IDLE;
      end
      default: begin
        next_state = RESET_STATE;
      end
    endcase
  end

`ifdef WINDOW_MEM_CLEAR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_addr <= '0;
    end else if (state == CLEAR) begin
      clr_addr <= clr_addr + ADDR_W'(1);
    end
  end
`endif

  // rd_pend/rd_lane trail the issued read address by one edge to match RAM latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      base_q   <= '0;
      single_q <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rdy_q    <= 1'b0;
      rvalid_q <= 1'b0;
      wdone_q  <= 1'b0;
      rd_pend  <= 1'b0;
      rd_lane  <= '0;
    end else begin
      rdy_q    <= (next_state == IDLE);
      wdone_q  <= (state == WRITE) && cnt_last;
      rvalid_q <= (state == FLUSH);
      rd_pend  <= (state == READ);
      rd_lane  <= cnt;
      if (rd_pend) begin
        rdata_q[int'(rd_lane)*DATA_W +: DATA_W] <= ram_q;
      end
      if (accept) begin
        base_q   <= bus.addr;
        single_q <= bus.single;
        wdata_q  <= bus.wdata;
        cnt      <= '0;
      end else if ((state == WRITE) || (state == READ)) begin
        cnt <= cnt_last ? '0 : cnt + CNT_W'(1);
      end
    end
  end

  window_mem_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  assign bus.rdy       = rdy_q;
  assign bus.rdata     = rdata_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.wdone     = wdone_q;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_window_mem.sv
// Bench for window_mem: directed and random window/single transfers against an array model.
// With WINDOW_MEM_CLEAR_EN the RAM is 2048 deep and the clear pattern is checked as well.
module tb_window_mem;
  import window_mem_pkg::*;

  localparam int DATA_W = 8;
`ifdef WINDOW_MEM_CLEAR_EN
  localparam int ADDR_W = 11;
  localparam int RDY_EDGES = 2048;
`else
  localparam int ADDR_W = 4;
  localparam int RDY_EDGES = 1;
`endif
  localparam int LANES = 4;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int WW    = LANES * DATA_W;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  window_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES)) bus ();

  window_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: RAM contents, held read window, expected queue
  logic [DATA_W-1:0] mem_m [DEPTH];
  logic [DATA_W-1:0] rd_m  [LANES];
  logic [DATA_W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] rand_window();
    logic [WW-1:0] w;
    for (int i = 0; i < LANES; i++) w[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    return w;
  endfunction

  function automatic logic [WW-1:0] pack4(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
    return {d, c, b, a};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) rd_m[i] = '0;
`ifdef WINDOW_MEM_CLEAR_EN
    for (int a = 0; a < DEPTH; a++) mem_m[a] = (a == 1000 || a == 1101) ? 8'h10 : 8'h00;
`endif
  endtask

  // driver: present a request, wait for rdy, then scramble inputs after acceptance
  task automatic issue(input logic we, input logic single, input int addr, input logic [WW-1:0] wd);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.req = 1'b1; bus.we = we; bus.single = single;
    bus.addr = ADDR_W'(addr); bus.wdata = wd;
    while (bus.rdy !== 1'b1 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("accept_timeout", 64'(guard < 5000), 64'd1);
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    bus.we = 1'($urandom_range(0, 1));
    bus.single = 1'($urandom_range(0, 1));
    bus.addr = ADDR_W'($urandom);
    bus.wdata = rand_window();
  endtask

  task automatic do_write(input int addr, input logic single, input logic [WW-1:0] wd);
    int n, k;
    n = single ? 1 : LANES;
    issue(1'b1, single, addr, wd);
    for (int i = 0; i < n; i++) mem_m[(addr + i) % DEPTH] = wd[i*DATA_W +: DATA_W];
    k = 0;
    while (bus.wdone !== 1'b1 && k < 100) begin
      @(posedge clk); #1; k++;
    end
    check("wdone_latency", 64'(k), 64'(n));
    check("rdy_after_write", 64'(bus.rdy), 64'd1);
    @(posedge clk); #1;
    check("wdone_width", 64'(bus.wdone), 64'd0);
  endtask

  task automatic do_read(input int addr, input logic single, input string tag);
    int n, k;
    logic [DATA_W-1:0] e;
    n = single ? 1 : LANES;
    issue(1'b0, single, addr, rand_window());
    for (int i = 0; i < n; i++) rd_m[i] = mem_m[(addr + i) % DEPTH];
    for (int i = 0; i < LANES; i++) exp_q.push_back(rd_m[i]);
    k = 0;
    while (bus.rvalid !== 1'b1 && k < 100) begin
      @(posedge clk); #1; k++;
    end
    check($sformatf("%s_rvalid_lat", tag), 64'(k), 64'(n + 1));
    check($sformatf("%s_rdy", tag), 64'(bus.rdy), 64'd1);
    for (int i = 0; i < LANES; i++) begin
      e = exp_q.pop_front();
      check($sformatf("%s_lane%0d", tag, i), 64'(bus.rdata[i*DATA_W +: DATA_W]), 64'(e));
    end
    @(posedge clk); #1;
    check($sformatf("%s_rvalid_width", tag), 64'(bus.rvalid), 64'd0);
  endtask

  task automatic check_outputs_reset(input string tag);
    check($sformatf("%s_rdy", tag), 64'(bus.rdy), 64'd0);
    check($sformatf("%s_rvalid", tag), 64'(bus.rvalid), 64'd0);
    check($sformatf("%s_wdone", tag), 64'(bus.wdone), 64'd0);
    check($sformatf("%s_rdata", tag), 64'(bus.rdata), 64'd0);
  endtask

  task automatic release_reset(input string tag);
    int k;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    k = 0;
    @(posedge clk); #1; k = 1;
    while (bus.rdy !== 1'b1 && k < DEPTH + 50) begin
      @(posedge clk); #1; k++;
    end
    check($sformatf("%s_rdy_edges", tag), 64'(k), 64'(RDY_EDGES));
    check($sformatf("%s_state", tag), 64'(bus.fsm_state), 64'(IDLE));
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [WW-1:0] wd;
    int acc[$];
    int wd_at[$];
    logic was_acc;
    int base;

    bus.req = 1'b0; bus.we = 1'b0; bus.single = 1'b0;
    bus.addr = '0; bus.wdata = '0;

    // reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_reset("por");
    release_reset("por");

`ifdef WINDOW_MEM_CLEAR_EN
    do_read(1000, 1'b1, "clr1000");
    check("clr1000_val", 64'(bus.rdata[7:0]), 64'h10);
    do_read(1101, 1'b1, "clr1101");
    check("clr1101_val", 64'(bus.rdata[7:0]), 64'h10);
    do_read(0, 1'b0, "clr0");
    check("clr0_all", 64'(bus.rdata), 64'd0);
`else
    for (int a = 0; a < DEPTH; a += LANES) do_write(a, 1'b0, rand_window());
`endif

    // basic window write then read
    do_write(2, 1'b0, pack4(8'h11, 8'h22, 8'h33, 8'h44));
    do_read(2, 1'b0, "win2");
    check("win2_raw", 64'(bus.rdata), 64'h44332211);

    // wrap past the top of memory, read back one word at a time
    base = DEPTH - 2;
    wd = pack4(8'hA1, 8'hA2, 8'hA3, 8'hA4);
    do_write(base, 1'b0, wd);
    for (int i = 0; i < LANES; i++) begin
      do_read((base + i) % DEPTH, 1'b1, $sformatf("wrap%0d", i));
      check($sformatf("wrap%0d_val", i), 64'(bus.rdata[7:0]), 64'(wd[i*8 +: 8]));
    end

    // single write inside a later window read
    do_write(7, 1'b1, {24'h0, 8'h5A});
    do_read(6, 1'b0, "sgl7");
    check("sgl7_lane1", 64'(bus.rdata[15:8]), 64'h5A);

    // req held high: three back-to-back window writes
    acc.delete(); wd_at.delete(); was_acc = 1'b0;
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.single = 1'b0;
    bus.addr = ADDR_W'(4); bus.wdata = rand_window();
    for (int c = 0; c < 3*(LANES+1) + LANES + 6; c++) begin
      if (c > 0) @(negedge clk);
      if (was_acc) begin
        if (acc.size() == 3) bus.req = 1'b0;
        else begin
          bus.addr = ADDR_W'($urandom);
          bus.wdata = rand_window();
        end
      end
      if (bus.wdone === 1'b1) wd_at.push_back(c);
      was_acc = (bus.req === 1'b1) && (bus.rdy === 1'b1);
      if (was_acc) begin
        acc.push_back(c);
        for (int i = 0; i < LANES; i++)
          mem_m[(int'(bus.addr) + i) % DEPTH] = bus.wdata[i*DATA_W +: DATA_W];
      end
    end
    bus.req = 1'b0;
    check("hold_accepts", 64'(acc.size()), 64'd3);
    check("hold_wdones", 64'(wd_at.size()), 64'd3);
    if (acc.size() == 3 && wd_at.size() == 3) begin
      check("hold_acc_gap", 64'(acc[1] - acc[0]), 64'(LANES + 1));
      check("hold_wd_gap1", 64'(wd_at[1] - wd_at[0]), 64'(LANES + 1));
      check("hold_wd_gap2", 64'(wd_at[2] - wd_at[1]), 64'(LANES + 1));
      check("hold_first_wd", 64'(wd_at[0] - acc[0]), 64'(LANES + 1));
    end
    do_read(int'(bus.addr) % DEPTH, 1'b0, "hold_rd");

    // reset in the middle of a window write, after two words are written
    do_write(8, 1'b0, rand_window());
    do_read(8, 1'b0, "pre_abort");
    wd = rand_window();
    issue(1'b1, 1'b0, 8, wd);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_outputs_reset("abort");
    mem_m[8] = wd[7:0];
    mem_m[9] = wd[15:8];
    repeat (2) @(negedge clk);
    release_reset("abort");
    do_read(8, 1'b0, "post_abort");

    // random mix against the model
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(int'($urandom_range(0, DEPTH - 1)), 1'($urandom_range(0, 2) == 0), rand_window());
      else
        do_read(int'($urandom_range(0, DEPTH - 1)), 1'($urandom_range(0, 2) == 0), $sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
